// File: rtl/game_io_responder_if.sv
// CPU data-bus slice seen by the game I/O block.
// The CPU side drives we/a/wd; the block answers with rd/hit.
interface game_io_responder_if;
    logic        we;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] rd;
    logic        hit;

    modport master (
        output we,
        output a,
        output wd,
        input  rd,
        input  hit
    );

    modport slave (
        input  we,
        input  a,
        input  wd,
        output rd,
        output hit
    );
endinterface

// File: rtl/game_io_responder.sv
// Game I/O peripheral: LFSR, down-count timer, button edge capture, LEDs.
// Sits beside data memory; reads are combinational from registered state.
module game_io_responder #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0400,
    parameter int          NBTN      = 4,
    parameter int          NLED      = 8,
    parameter int          PRESCALE  = 50000,
    parameter logic [31:0] SEED      = 32'hACE1_2345
) (
    input  logic            clk,
    input  logic            rst,
    game_io_responder_if.slave bus,
    input  logic [NBTN-1:0] btn,
    output logic [NLED-1:0] leds,
    output logic            irq_timer
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

    logic [2:0]      off;
    logic            wr;
    logic            wr_status;
    logic            wr_rand;
    logic            wr_timer;
    logic            wr_leds;

    logic [31:0]     lfsr;
    logic [31:0]     lfsr_adv;
    logic [31:0]     count;
    logic [PW-1:0]   presc;
    logic            tick;
    logic            expire_now;
    logic            expired;
    logic            pending;
    logic [NBTN-1:0] btn_mask;
    logic [NLED-1:0] led_reg;
    logic [NBTN-1:0] sync1;
    logic [NBTN-1:0] sync2;
    logic [NBTN-1:0] sync3;
    logic [NBTN-1:0] rise;

    logic            unused_addr_lsb;

    assign unused_addr_lsb = &{1'b0, bus.a[1:0]};

    assign bus.hit   = (bus.a[31:5] == BASE_ADDR[31:5]);
    assign off       = bus.a[4:2];
    assign wr        = bus.we && bus.hit;
    assign wr_status = wr && (off == 3'd0);
    assign wr_rand   = wr && (off == 3'd2);
    assign wr_timer  = wr && (off == 3'd3);
    assign wr_leds   = wr && (off == 3'd4);

    assign lfsr_adv   = (lfsr >> 1) ^ (lfsr[0] ? 32'h8020_0003 : 32'h0);
    assign tick       = (count != 32'd0) && (presc == PRE_LAST);
    assign expire_now = tick && (count == 32'd1) && !wr_timer;
    assign rise       = sync2 & ~sync3;

    assign leds      = led_reg;
    assign irq_timer = expired;

    // Register read mux; unmapped offsets and misses read zero.
    always_comb begin
        bus.rd = 32'h0;
        if (bus.hit) begin
            case (off)
                3'd0:    bus.rd = {30'h0, expired, pending};
                3'd1:    bus.rd = {{(32-NBTN){1'b0}}, btn_mask};
                3'd2:    bus.rd = lfsr;
                3'd3:    bus.rd = count;
                3'd4:    bus.rd = {{(32-NLED){1'b0}}, led_reg};
                default: bus.rd = 32'h0;
            endcase
        end
    end

    // LFSR: free-running, a store reseeds it (zero would lock it up).
    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr <= SEED;
        end else if (wr_rand) begin
            lfsr <= (bus.wd == 32'h0) ? 32'h1 : bus.wd;
        end else begin
            lfsr <= lfsr_adv;
        end
    end

    // Timer: prescaler runs only while the count is nonzero.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= 32'h0;
            presc <= '0;
        end else if (wr_timer) begin
            count <= bus.wd;
            presc <= '0;
        end else if (count != 32'h0) begin
            if (tick) begin
                presc <= '0;
                count <= count - 32'd1;
            end else begin
                presc <= presc + PW'(1);
            end
        end
    end

    // Status flags: a new event in the same cycle wins over the clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            expired  <= 1'b0;
            pending  <= 1'b0;
            btn_mask <= '0;
        end else begin
            if (expire_now) begin
                expired <= 1'b1;
            end else if (wr_status && bus.wd[1]) begin
                expired <= 1'b0;
            end
            if (rise != '0) begin
                pending <= 1'b1;
            end else if (wr_status && bus.wd[0]) begin
                pending <= 1'b0;
            end
            if (wr_status && bus.wd[0]) begin
                btn_mask <= rise;
            end else begin
                btn_mask <= btn_mask | rise;
            end
        end
    end

    // Button synchronizer plus delayed copy for rising-edge detect.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
            sync3 <= '0;
        end else begin
            sync1 <= btn;
            sync2 <= sync1;
            sync3 <= sync2;
        end
    end

    // LED output register.
    always_ff @(posedge clk) begin
        if (rst) begin
            led_reg <= '0;
        end else if (wr_leds) begin
            led_reg <= bus.wd[NLED-1:0];
        end
    end

endmodule

// File: tb/tb_game_io_responder.sv
// Bench for game_io_responder: cycle model plus directed literal checks.
// Timer prescale shortened to 4 so countdowns fit in a short run.
module tb_game_io_responder;

    localparam int          P    = 4;
    localparam logic [31:0] BASE = 32'h0000_0400;
    localparam logic [31:0] SEED = 32'hACE1_2345;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] btn;
    logic [7:0] leds;
    logic       irq_timer;

    game_io_responder_if bus ();

    game_io_responder #(
        .BASE_ADDR(BASE),
        .NBTN(4),
        .NLED(8),
        .PRESCALE(P),
        .SEED(SEED)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus),
        .btn(btn),
        .leds(leds),
        .irq_timer(irq_timer)
    );

    always #5 clk = ~clk;

    int n_tot  = 0;
    int n_pass = 0;
    int cyc_n  = 0;

    // Model state
    logic        mvalid = 1'b0;
    logic [31:0] m_lfsr;
    logic [31:0] m_cnt;
    int          m_pre;
    logic        m_exp;
    logic        m_pend;
    logic [3:0]  m_mask;
    logic [7:0]  m_leds;
    logic [3:0]  hist [0:8191];
    int          hp;

    logic        m_hit;
    logic        m_wr;
    logic [2:0]  m_off;
    logic [3:0]  m_rise;
    logic        m_tick;

    assign m_hit  = (bus.a[31:5] == BASE[31:5]);
    assign m_wr   = bus.we && m_hit;
    assign m_off  = bus.a[4:2];
    assign m_rise = (hp >= 3) ? (hist[hp-2] & ~hist[hp-3]) : 4'h0;
    assign m_tick = (m_cnt != 0) && (m_pre == P - 1);

    function automatic logic [31:0] m_rd(input logic [31:0] addr);
        if (addr[31:5] != BASE[31:5]) return 32'h0;
        case (addr[4:2])
            3'd0: return {30'h0, m_exp, m_pend};
            3'd1: return {28'h0, m_mask};
            3'd2: return m_lfsr;
            3'd3: return m_cnt;
            3'd4: return {24'h0, m_leds};
            default: return 32'h0;
        endcase
    endfunction

    // Model update: button samples land in a history array and a rise is
    // the sample from two edges ago being high while three ago was low.
    always @(posedge clk) begin
        cyc_n <= cyc_n + 1;
        if (rst) begin
            mvalid <= 1'b1;
            m_lfsr <= SEED;
            m_cnt  <= 0;
            m_pre  <= 0;
            m_exp  <= 1'b0;
            m_pend <= 1'b0;
            m_mask <= 4'h0;
            m_leds <= 8'h0;
            hist[0] <= 4'h0;
            hist[1] <= 4'h0;
            hist[2] <= 4'h0;
            hp <= 3;
        end else if (mvalid) begin
            hist[hp] <= btn;
            hp <= hp + 1;
            if (m_wr && m_off == 3'd2)
                m_lfsr <= (bus.wd == 0) ? 32'h1 : bus.wd;
            else
                m_lfsr <= {1'b0, m_lfsr[31:1]}
                          ^ (m_lfsr[0] ? 32'h8020_0003 : 32'h0);
            if (m_wr && m_off == 3'd3) begin
                m_cnt <= bus.wd;
                m_pre <= 0;
            end else if (m_tick) begin
                m_cnt <= m_cnt - 1;
                m_pre <= 0;
            end else if (m_cnt != 0) begin
                m_pre <= m_pre + 1;
            end
            if (m_tick && m_cnt == 1 && !(m_wr && m_off == 3'd3))
                m_exp <= 1'b1;
            else if (m_wr && m_off == 3'd0 && bus.wd[1])
                m_exp <= 1'b0;
            if (m_rise != 0)
                m_pend <= 1'b1;
            else if (m_wr && m_off == 3'd0 && bus.wd[0])
                m_pend <= 1'b0;
            if (m_wr && m_off == 3'd0 && bus.wd[0])
                m_mask <= m_rise;
            else
                m_mask <= m_mask | m_rise;
            if (m_wr && m_off == 3'd4)
                m_leds <= bus.wd[7:0];
        end
    end

    // Per-cycle compare of every output against the model.
    always @(negedge clk) begin
        if (mvalid) begin
            n_tot = n_tot + 4;
            if (bus.hit === m_hit) n_pass = n_pass + 1;
            else $display("FAIL cyc%0d hit got %b exp %b", cyc_n, bus.hit, m_hit);
            if (bus.rd === m_rd(bus.a)) n_pass = n_pass + 1;
            else $display("FAIL cyc%0d rd a=%h got %h exp %h",
                          cyc_n, bus.a, bus.rd, m_rd(bus.a));
            if (leds === m_leds) n_pass = n_pass + 1;
            else $display("FAIL cyc%0d leds got %h exp %h", cyc_n, leds, m_leds);
            if (irq_timer === m_exp) n_pass = n_pass + 1;
            else $display("FAIL cyc%0d irq got %b exp %b", cyc_n, irq_timer, m_exp);
        end
    end

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tot = n_tot + 1;
        if (got === exp) n_pass = n_pass + 1;
        else $display("FAIL %s got %h exp %h", nm, got, exp);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] data);
        bus.we = 1'b1;
        bus.a  = addr;
        bus.wd = data;
        cyc();
        bus.we = 1'b0;
    endtask

    task automatic peek(input string nm, input logic [31:0] addr,
                        input logic [31:0] exp);
        bus.a = addr;
        #1;
        chk(nm, bus.rd, exp);
    endtask

    int n;
    logic seen;

    initial begin
        rst    = 1'b1;
        btn    = 4'h0;
        bus.we = 1'b0;
        bus.a  = 32'h0;
        bus.wd = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        chk("rst_leds", {24'h0, leds}, 32'h0);
        chk("rst_irq", {31'h0, irq_timer}, 32'h0);
        peek("rand_seed", 32'h408, 32'hACE1_2345);
        cyc();
        peek("rand_step", 32'h408, 32'hD650_91A1);

        wr(32'h410, 32'h5A);
        chk("leds_out", {24'h0, leds}, 32'h5A);
        peek("leds_rd", 32'h410, 32'h5A);
        bus.a = 32'h800;
        #1;
        chk("miss_hit", {31'h0, bus.hit}, 32'h0);
        chk("miss_rd", bus.rd, 32'h0);
        wr(32'h414, 32'hFFFF_FFFF);
        peek("unmapped_rd", 32'h414, 32'h0);
        peek("leds_keep", 32'h410, 32'h5A);

        wr(32'h40C, 32'd3);
        n = 0;
        while (irq_timer !== 1'b1 && n < 50) begin
            cyc();
            n++;
        end
        chk("expire_cycles", n, 12);
        peek("status_exp", 32'h400, 32'h2);
        wr(32'h400, 32'h2);
        chk("irq_clr", {31'h0, irq_timer}, 32'h0);
        wr(32'h40C, 32'd0);
        seen = 1'b0;
        repeat (40) begin
            cyc();
            if (irq_timer) seen = 1'b1;
        end
        chk("idle_no_exp", {31'h0, seen}, 32'h0);

        btn = 4'b0010;
        cyc();
        cyc();
        peek("btn_early", 32'h400, 32'h0);
        btn = 4'b0000;
        cyc();
        peek("btn_status", 32'h400, 32'h1);
        peek("btn_mask1", 32'h404, 32'h2);
        btn = 4'b1000;
        repeat (3) cyc();
        peek("btn_mask2", 32'h404, 32'hA);
        wr(32'h400, 32'h1);
        peek("btn_clr_st", 32'h400, 32'h0);
        peek("btn_clr_mk", 32'h404, 32'h0);
        btn = 4'b1100;
        repeat (3) cyc();
        peek("btn_mask3", 32'h404, 32'h4);
        btn = 4'b1101;
        cyc();
        cyc();
        wr(32'h400, 32'h1);
        peek("race_st", 32'h400, 32'h1);
        peek("race_mk", 32'h404, 32'h1);
        btn = 4'b0000;
        repeat (4) cyc();
        peek("fall_none", 32'h404, 32'h1);

        wr(32'h408, 32'h0);
        peek("seed_zero", 32'h408, 32'h1);
        wr(32'h408, 32'hDEAD_BEEF);
        peek("seed_load", 32'h408, 32'hDEAD_BEEF);

        wr(32'h40C, 32'd100);
        repeat (20) cyc();
        peek("mid_count", 32'h40C, 32'd95);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        peek("rst_count", 32'h40C, 32'd0);
        seen = 1'b0;
        repeat (1000) begin
            cyc();
            if (irq_timer) seen = 1'b1;
        end
        chk("rst_no_exp", {31'h0, seen}, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
